// File: rtl/thread_fetch_sched_pkg.sv
// Shared types for the per-thread fetch scheduler: thread ids, thread states
// and the sequential fetch stride.
package thread_fetch_sched_pkg;

  localparam int TID_W = 2;

  typedef logic [TID_W-1:0] threadid_t;
  typedef logic [31:0]      instr_t;

  typedef enum logic {
    READY     = 1'b0,
    WAIT_FILL = 1'b1
  } thread_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/thread_fetch_sched_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr,
// scanning upward with wrap-around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    // Scan from the farthest offset down, so the nearest requester is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/thread_fetch_sched.sv
// Per-thread fetch scheduler: round-robin thread pick, then advance, replay or
// park the fetched thread on the same-cycle miss/hazard verdict.
module thread_fetch_sched
  import thread_fetch_sched_pkg::*;
#(
  parameter int          N_THREADS = 4,
  parameter logic [31:0] BOOT_PC   = 32'h0000_1000,
  parameter int          CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 fetch_valid,
  output threadid_t            fetch_thread,
  output logic [31:0]          fetch_pc,
  input  logic                 itlb_miss,
  input  logic                 icache_miss,
  input  logic                 hz_isvalid,
  input  logic                 fill_done,
  input  threadid_t            fill_thread,
  input  logic                 redirect_valid,
  input  threadid_t            redirect_thread,
  input  logic [31:0]          redirect_pc,
  output logic [N_THREADS-1:0] thread_ready,
  output logic [CNT_W-1:0]     replay_cnt
);

  thread_state_t      r_state [N_THREADS];
  logic [31:0]        r_pc    [N_THREADS];
  threadid_t          r_rr_ptr;
  logic [CNT_W-1:0]   r_replay_cnt;

  logic [N_THREADS-1:0] w_ready;
  logic [N_THREADS-1:0] w_sel;
  logic                 w_gnt_valid;
  threadid_t            w_gnt_idx;
  logic                 w_miss;
  logic                 w_redir_sel;

  rr_arbiter #(
    .N  (N_THREADS),
    .IW ($bits(threadid_t))
  ) u_arb (
    .req       (w_ready),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_miss      = itlb_miss | icache_miss;
  assign w_redir_sel = redirect_valid && (redirect_thread == w_gnt_idx);

  assign fetch_valid  = rst & w_gnt_valid;
  assign fetch_thread = rst ? w_gnt_idx : '0;
  assign fetch_pc     = rst ? r_pc[w_gnt_idx] : BOOT_PC;
  assign thread_ready = rst ? w_ready : '0;
  assign replay_cnt   = r_replay_cnt;

  generate
    for (genvar gi = 0; gi < N_THREADS; gi++) begin : g_thread
      assign w_ready[gi] = (r_state[gi] == READY);
      assign w_sel[gi]   = w_gnt_valid && (w_gnt_idx == threadid_t'(gi));

      // Redirect outranks everything; a fetched thread is READY, so a fill never races its miss.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_state[gi] <= READY;
          r_pc[gi]    <= BOOT_PC;
        end else if (redirect_valid && (redirect_thread == threadid_t'(gi))) begin
          r_state[gi] <= READY;
          r_pc[gi]    <= redirect_pc;
        end else if (w_sel[gi]) begin
          if (w_miss) begin
            r_state[gi] <= WAIT_FILL;
          end else if (hz_isvalid) begin
            r_pc[gi] <= r_pc[gi] + PC_STEP;
          end
        end else if (r_state[gi] == WAIT_FILL && fill_done &&
                     (fill_thread == threadid_t'(gi))) begin
          r_state[gi] <= READY;
        end
      end
    end
  endgenerate

  // The pointer moves past every fetched thread so a replaying thread cannot starve the rest.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr     <= '0;
      r_replay_cnt <= '0;
    end else if (w_gnt_valid) begin
      r_rr_ptr <= threadid_t'(w_gnt_idx + 1'b1);
      if (!w_miss && !hz_isvalid && !w_redir_sel && (r_replay_cnt != '1)) begin
        r_replay_cnt <= r_replay_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Directed table of per-cycle stimulus and expected scheduler outputs, plus a
// hand-written redirect/PC-wrap sequence.
module tb_thread_fetch_sched;
  import thread_fetch_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  threadid_t   fetch_thread;
  logic [31:0] fetch_pc;
  logic        itlb_miss, icache_miss, hz_isvalid;
  logic        fill_done;
  threadid_t   fill_thread;
  logic        redirect_valid;
  threadid_t   redirect_thread;
  logic [31:0] redirect_pc;
  logic [3:0]  thread_ready;
  logic [15:0] replay_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  thread_fetch_sched #(
    .N_THREADS (4),
    .BOOT_PC   (32'h0000_1000),
    .CNT_W     (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_valid     (fetch_valid),
    .fetch_thread    (fetch_thread),
    .fetch_pc        (fetch_pc),
    .itlb_miss       (itlb_miss),
    .icache_miss     (icache_miss),
    .hz_isvalid      (hz_isvalid),
    .fill_done       (fill_done),
    .fill_thread     (fill_thread),
    .redirect_valid  (redirect_valid),
    .redirect_thread (redirect_thread),
    .redirect_pc     (redirect_pc),
    .thread_ready    (thread_ready),
    .replay_cnt      (replay_cnt)
  );

  typedef struct packed {
    logic        rst_v;
    logic        itlb;
    logic        icache;
    logic        hz;
    logic        fd;
    logic [1:0]  ft;
    logic        rv;
    logic [1:0]  rt;
    logic [31:0] rpc;
    logic        e_fv;
    logic [1:0]  e_ft;
    logic [31:0] e_pc;
    logic [3:0]  e_rdy;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 48;
  vec_t vecs [NV];

  function automatic vec_t mk(input int rs, input int it, input int ic, input int hz,
                              input int fd, input int ft, input int rv, input int rt,
                              input logic [31:0] rpc, input int efv, input int eft,
                              input logic [31:0] epc, input int erdy, input int ecnt);
    vec_t v;
    v.rst_v  = rs[0];
    v.itlb   = it[0];
    v.icache = ic[0];
    v.hz     = hz[0];
    v.fd     = fd[0];
    v.ft     = ft[1:0];
    v.rv     = rv[0];
    v.rt     = rt[1:0];
    v.rpc    = rpc;
    v.e_fv   = efv[0];
    v.e_ft   = eft[1:0];
    v.e_pc   = epc;
    v.e_rdy  = erdy[3:0];
    v.e_cnt  = ecnt[15:0];
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rst_v;
    itlb_miss       = v.itlb;
    icache_miss     = v.icache;
    hz_isvalid      = v.hz;
    fill_done       = v.fd;
    fill_thread     = v.ft;
    redirect_valid  = v.rv;
    redirect_thread = v.rt;
    redirect_pc     = v.rpc;
  endtask

  task automatic chk_fetch(input int idx, input int t, input logic [31:0] pc);
    chk("fetch_valid", idx, {31'd0, fetch_valid}, 32'd1);
    chk("fetch_thread", idx, {30'd0, fetch_thread}, t);
    chk("fetch_pc", idx, fetch_pc, pc);
    $display("step %0d: thread %0d pc %h ready %b replay %0d",
             idx, fetch_thread, fetch_pc, thread_ready, replay_cnt);
  endtask

  initial begin
    // Quiet cycles: 8 cycles of plain round-robin from boot
    vecs[0]  = mk(1,0,0,1,0,0,0,0,0, 1,0,32'h1000,'hF,0);
    vecs[1]  = mk(1,0,0,1,0,0,0,0,0, 1,1,32'h1000,'hF,0);
    vecs[2]  = mk(1,0,0,1,0,0,0,0,0, 1,2,32'h1000,'hF,0);
    vecs[3]  = mk(1,0,0,1,0,0,0,0,0, 1,3,32'h1000,'hF,0);
    vecs[4]  = mk(1,0,0,1,0,0,0,0,0, 1,0,32'h1004,'hF,0);
    vecs[5]  = mk(1,0,0,1,0,0,0,0,0, 1,1,32'h1004,'hF,0);
    vecs[6]  = mk(1,0,0,1,0,0,0,0,0, 1,2,32'h1004,'hF,0);
    vecs[7]  = mk(1,0,0,1,0,0,0,0,0, 1,3,32'h1004,'hF,0);
    // Thread 1 icache miss, skipped, then filled and refetched at the held pc
    vecs[8]  = mk(1,0,0,1,0,0,0,0,0, 1,0,32'h1008,'hF,0);
    vecs[9]  = mk(1,0,1,1,0,0,0,0,0, 1,1,32'h1008,'hF,0);
    vecs[10] = mk(1,0,0,1,0,0,0,0,0, 1,2,32'h1008,'hD,0);
    vecs[11] = mk(1,0,0,1,0,0,0,0,0, 1,3,32'h1008,'hD,0);
    vecs[12] = mk(1,0,0,1,0,0,0,0,0, 1,0,32'h100C,'hD,0);
    vecs[13] = mk(1,0,0,1,1,1,0,0,0, 1,2,32'h100C,'hD,0);
    vecs[14] = mk(1,0,0,1,0,0,0,0,0, 1,3,32'h100C,'hF,0);
    vecs[15] = mk(1,0,0,1,0,0,0,0,0, 1,0,32'h1010,'hF,0);
    vecs[16] = mk(1,0,0,1,0,0,0,0,0, 1,1,32'h1008,'hF,0);
    // Thread 2 hazarded for three rounds
    vecs[17] = mk(1,0,0,0,0,0,0,0,0, 1,2,32'h1010,'hF,0);
    vecs[18] = mk(1,0,0,1,0,0,0,0,0, 1,3,32'h1010,'hF,1);
    vecs[19] = mk(1,0,0,1,0,0,0,0,0, 1,0,32'h1014,'hF,1);
    vecs[20] = mk(1,0,0,1,0,0,0,0,0, 1,1,32'h100C,'hF,1);
    vecs[21] = mk(1,0,0,0,0,0,0,0,0, 1,2,32'h1010,'hF,1);
    vecs[22] = mk(1,0,0,1,0,0,0,0,0, 1,3,32'h1014,'hF,2);
    vecs[23] = mk(1,0,0,1,0,0,0,0,0, 1,0,32'h1018,'hF,2);
    vecs[24] = mk(1,0,0,1,0,0,0,0,0, 1,1,32'h1010,'hF,2);
    vecs[25] = mk(1,0,0,0,0,0,0,0,0, 1,2,32'h1010,'hF,2);
    // Thread 3 itlb miss, redirect while waiting, stale fill ignored
    vecs[26] = mk(1,1,0,1,0,0,0,0,0, 1,3,32'h1018,'hF,3);
    vecs[27] = mk(1,0,0,1,0,0,1,3,32'h2000, 1,0,32'h101C,'h7,3);
    vecs[28] = mk(1,0,0,1,1,3,0,0,0, 1,1,32'h1014,'hF,3);
    vecs[29] = mk(1,0,0,1,0,0,0,0,0, 1,2,32'h1010,'hF,3);
    vecs[30] = mk(1,0,0,1,0,0,0,0,0, 1,3,32'h2000,'hF,3);
    // Redirect beats increment; miss beats hazard (no replay count)
    vecs[31] = mk(1,0,0,1,0,0,1,0,32'h3000, 1,0,32'h1020,'hF,3);
    vecs[32] = mk(1,0,1,0,0,0,0,0,0, 1,1,32'h1018,'hF,3);
    vecs[33] = mk(1,0,0,1,0,0,0,0,0, 1,2,32'h1014,'hD,3);
    vecs[34] = mk(1,0,0,1,0,0,0,0,0, 1,3,32'h2004,'hD,3);
    vecs[35] = mk(1,0,0,1,0,0,0,0,0, 1,0,32'h3000,'hD,3);
    vecs[36] = mk(1,1,0,1,0,0,0,0,0, 1,2,32'h1018,'hD,3);
    vecs[37] = mk(1,0,0,1,0,0,0,0,0, 1,3,32'h2008,'h9,3);
    // Reset with threads 1 and 2 waiting
    vecs[38] = mk(0,0,0,1,0,0,0,0,0, 0,0,32'h1000,'h0,3);
    vecs[39] = mk(0,0,0,1,0,0,0,0,0, 0,0,32'h1000,'h0,0);
    // All threads park; with none ready the miss/hazard inputs are ignored
    vecs[40] = mk(1,0,1,1,0,0,0,0,0, 1,0,32'h1000,'hF,0);
    vecs[41] = mk(1,0,1,1,0,0,0,0,0, 1,1,32'h1000,'hE,0);
    vecs[42] = mk(1,0,1,1,0,0,0,0,0, 1,2,32'h1000,'hC,0);
    vecs[43] = mk(1,0,1,1,0,0,0,0,0, 1,3,32'h1000,'h8,0);
    vecs[44] = mk(1,0,0,0,1,2,0,0,0, 0,0,32'h0,'h0,0);
    vecs[45] = mk(1,0,0,0,0,0,0,0,0, 1,2,32'h1000,'h4,0);
    vecs[46] = mk(1,0,0,1,1,0,0,0,0, 1,2,32'h1000,'h4,1);
    vecs[47] = mk(1,0,0,1,0,0,0,0,0, 1,0,32'h1000,'h5,1);

    drive(mk(0,0,0,1,0,0,0,0,0, 0,0,0,0,0));
    repeat (2) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      chk("fetch_valid", k, {31'd0, fetch_valid}, {31'd0, vecs[k].e_fv});
      chk("thread_ready", k, {28'd0, thread_ready}, {28'd0, vecs[k].e_rdy});
      chk("replay_cnt", k, {16'd0, replay_cnt}, {16'd0, vecs[k].e_cnt});
      if (vecs[k].e_fv || !vecs[k].rst_v) begin
        chk("fetch_thread", k, {30'd0, fetch_thread}, {30'd0, vecs[k].e_ft});
        chk("fetch_pc", k, fetch_pc, vecs[k].e_pc);
      end
      $display("step %0d: rst %b valid %b thread %0d pc %h ready %b replay %0d",
               k, rst, fetch_valid, fetch_thread, fetch_pc, thread_ready, replay_cnt);
    end

    // Redirect thread 2 to the top of the address space while it is fetched, then wrap
    @(negedge clk);
    drive(mk(1,0,0,1,0,0,1,2,32'hFFFF_FFFC, 0,0,0,0,0));
    #1 chk_fetch(48, 2, 32'h1004);
    @(negedge clk);
    drive(mk(1,0,0,1,0,0,0,0,0, 0,0,0,0,0));
    #1 chk_fetch(49, 0, 32'h1004);
    @(negedge clk);
    #1 chk_fetch(50, 2, 32'hFFFF_FFFC);
    @(negedge clk);
    #1 chk_fetch(51, 0, 32'h1008);
    @(negedge clk);
    #1 chk_fetch(52, 2, 32'h0000_0000);
    chk("replay_cnt_final", 52, {16'd0, replay_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
